// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-master SDRAM port arbiter.
package sdram_arb_pkg;

   localparam int unsigned ADDR_W_DEF   = 22;
   localparam int unsigned DATA_W_DEF   = 16;
   localparam int unsigned MAX_PEND_DEF = 8;

   typedef logic mid_t;
   localparam mid_t M_CPU = 1'b0;
   localparam mid_t M_DMA = 1'b1;

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Single-beat Avalon-MM link; master modport issues commands, slave modport answers them.
interface sdram_port_arbiter_if
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W/8-1:0] byteenable;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// Depth x 1-bit tag FIFO recording which master owns each outstanding read.
module sdram_arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int unsigned Depth = MAX_PEND_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  mid_t                     din_i,
   input  logic                     pop_i,
   output mid_t                     dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Depth-1:0] mem_q, mem_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
   always_comb begin
      do_pop   = pop_i & (count_q != '0);
      do_push  = push_i & ((count_q != CntW'(Depth)) | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM slave between CPU (m0) and DMA (m1) masters,
// with pipelined reads routed back to their owner through a tag FIFO.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
   input logic                  clk_clk,
   input logic                  reset_reset,
   sdram_port_arbiter_if.slave  m0,
   sdram_port_arbiter_if.slave  m1,
   sdram_port_arbiter_if.master s
);
   localparam int unsigned CntW = $clog2(MAX_PEND) + 1;

   arb_state_t          state_q, state_d;
   mid_t                gnt_id_q, gnt_id_d, rr_ptr_q, rr_ptr_d, gnt_id;
   logic                gnt_vld, gnt_rd, accept;
   logic                elig0, elig1, can_read;
   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   mid_t                fifo_head;
   logic [CntW-1:0]     pend_cnt;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W/8-1:0] sel_be;
   logic                sel_rd, sel_wr;

   assign fifo_pop = s.readdatavalid & ~fifo_empty & ~reset_reset;
   assign can_read = ~fifo_full | fifo_pop;
   // read+write together counts as a read, so it needs a free tag slot
   assign elig0    = m0.read ? can_read : m0.write;
   assign elig1    = m1.read ? can_read : m1.write;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q  <= UNLOCKED;
         gnt_id_q <= M_CPU;
         rr_ptr_q <= M_CPU;
      end else begin
         state_q  <= state_d;
         gnt_id_q <= gnt_id_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_id_d = gnt_id_q;
      rr_ptr_d = rr_ptr_q;
      gnt_id   = gnt_id_q;
      gnt_vld  = 1'b0;
      unique case (state_q)
         UNLOCKED: begin
            gnt_vld = elig0 | elig1;
            if (elig0 && elig1) gnt_id = rr_ptr_q;
            else if (elig1)     gnt_id = M_DMA;
            else                gnt_id = M_CPU;
            if (gnt_vld && s.waitrequest) begin
               state_d  = LOCKED;
               gnt_id_d = gnt_id;
            end
         end
         LOCKED: begin
            // A locked master that drops its request releases the lock.
            gnt_vld = (gnt_id_q == M_DMA) ? (m1.read | m1.write) : (m0.read | m0.write);
            if (!gnt_vld || !s.waitrequest) state_d = UNLOCKED;
         end
         default: state_d = UNLOCKED;
      endcase
      accept = gnt_vld & ~s.waitrequest & ~reset_reset;
      if (accept) rr_ptr_d = ~gnt_id;
   end

   assign gnt_rd    = (gnt_id == M_DMA) ? m1.read : m0.read;
   assign fifo_push = accept & gnt_rd;

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      sel_rd    = 1'b0;
      sel_wr    = 1'b0;
      if (gnt_vld && !reset_reset) begin
         if (gnt_id == M_DMA) begin
            sel_addr  = m1.address;
            sel_wdata = m1.writedata;
            sel_be    = m1.byteenable;
            sel_rd    = m1.read;
            sel_wr    = m1.write & ~m1.read;
         end else begin
            sel_addr  = m0.address;
            sel_wdata = m0.writedata;
            sel_be    = m0.byteenable;
            sel_rd    = m0.read;
            sel_wr    = m0.write & ~m0.read;
         end
      end
      s.address        = sel_addr;
      s.writedata      = sel_wdata;
      s.byteenable     = sel_be;
      s.read           = sel_rd;
      s.write          = sel_wr;
      m0.waitrequest   = ~(accept && gnt_id == M_CPU);
      m1.waitrequest   = ~(accept && gnt_id == M_DMA);
      m0.readdatavalid = fifo_pop & (fifo_head == M_CPU);
      m1.readdatavalid = fifo_pop & (fifo_head == M_DMA);
      m0.readdata      = m0.readdatavalid ? s.readdata : '0;
      m1.readdata      = m1.readdatavalid ? s.readdata : '0;
   end

   sdram_arb_tag_fifo #(
      .Depth (MAX_PEND)
   ) u_fifo (
      .clk_i   (clk_clk),
      .rst_i   (reset_reset),
      .push_i  (fifo_push),
      .din_i   (gnt_id),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (pend_cnt)
   );

`ifndef SYNTHESIS
   assert property (@(posedge clk_clk) disable iff (reset_reset)
      !(s.readdatavalid && fifo_empty))
      else $error("readdatavalid with no outstanding read");
   assert property (@(posedge clk_clk) disable iff (reset_reset)
      pend_cnt <= CntW'(MAX_PEND))
      else $error("pending read count overflow");
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: vector table for arbitration plus hand sequences and a read
// scoreboard fed by a fixed-latency SDRAM model.
module tb_sdram_port_arbiter;
   import sdram_arb_pkg::*;

   localparam int unsigned AW = 22;
   localparam int unsigned DW = 16;
   localparam int unsigned MP = 8;
   localparam logic [AW-1:0] A0 = 22'h000010;
   localparam logic [AW-1:0] A1 = 22'h000020;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
   sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
   sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

   sdram_port_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_PEND (MP)
   ) dut (
      .clk_clk     (clk),
      .reset_reset (rst),
      .m0          (m0_if),
      .m1          (m1_if),
      .s           (s_if)
   );

   typedef struct {logic mid; logic [DW-1:0] data;} exp_t;
   typedef struct {logic [DW-1:0] data; int due;} rsp_t;
   typedef struct {
      bit m0r, m0w, m1r, m1w, sw;
      bit er, ew, e0w, e1w;
      logic [AW-1:0] ea;
   } vec_t;

   exp_t exp_q[$];
   rsp_t rsp_q[$];
   vec_t tbl[10];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   pend_tb = 0;
   bit   rsp_en, force_rdv, mdl_rdv, chk_pend;

   function automatic logic [DW-1:0] mem_f(logic [AW-1:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle_all();
      m0_if.read = 0; m0_if.write = 0; m0_if.address = '0; m0_if.writedata = '0;
      m0_if.byteenable = 2'b11;
      m1_if.read = 0; m1_if.write = 0; m1_if.address = '0; m1_if.writedata = '0;
      m1_if.byteenable = 2'b11;
      s_if.waitrequest = 0;
   endtask

   task automatic settle();
      mdl_rdv = 0;
      s_if.readdatavalid = 0;
      s_if.readdata = '0;
      if (force_rdv) begin
         s_if.readdatavalid = 1;
         s_if.readdata = 16'hDEAD;
      end else if (rsp_en && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         s_if.readdatavalid = 1;
         s_if.readdata = rsp_q[0].data;
         mdl_rdv = 1;
      end
      #3;
   endtask

   task automatic advance();
      exp_t e;
      logic [1:0] got;
      if (!rst) begin
         if (s_if.read && !s_if.waitrequest) begin
            rsp_q.push_back('{data: mem_f(s_if.address), due: cyc + 3});
            pend_tb++;
         end
         if (m0_if.read && !m0_if.waitrequest)
            exp_q.push_back('{mid: 1'b0, data: mem_f(m0_if.address)});
         if (m1_if.read && !m1_if.waitrequest)
            exp_q.push_back('{mid: 1'b1, data: mem_f(m1_if.address)});
      end
      got = {m1_if.readdatavalid, m0_if.readdatavalid};
      if (mdl_rdv) begin
         rsp_q.delete(0);
         pend_tb--;
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rdv_unexpected: got %b expected no pending read", got);
         end else begin
            e = exp_q.pop_front();
            chk("rdv_route", got, e.mid ? 2'b10 : 2'b01);
            chk("rdv_data", e.mid ? m1_if.readdata : m0_if.readdata, e.data);
         end
      end else if (got != 2'b00) begin
         chk("rdv_spurious", got, 2'b00);
      end
      @(posedge clk); #1;
      cyc++;
      if (chk_pend) chk("pend_cnt", dut.u_fifo.count_o, pend_tb);
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   task automatic do_reset(input bit check);
      rst = 1;
      idle_all();
      m0_if.write = 1;
      m1_if.read = 1;
      force_rdv = 1;
      settle();
      if (check) begin
         chk("rst_s_read", s_if.read, 0);
         chk("rst_s_write", s_if.write, 0);
         chk("rst_m0_wait", m0_if.waitrequest, 1);
         chk("rst_m1_wait", m1_if.waitrequest, 1);
         chk("rst_rdv", {m1_if.readdatavalid, m0_if.readdatavalid}, 0);
         chk("rst_s_addr", s_if.address, 0);
         chk("rst_pend", dut.u_fifo.count_o, 0);
         chk("rst_rr", dut.rr_ptr_q, 0);
      end
      advance();
      rst = 0;
      force_rdv = 0;
      idle_all();
      exp_q.delete();
      rsp_q.delete();
      pend_tb = 0;
   endtask

   task automatic drain();
      idle_all();
      rsp_en = 1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a0, a1;
      bit acc0, acc1;
      //           m0r m0w m1r m1w sw   er ew e0w e1w  addr
      tbl[0] = '{0, 1, 0, 0, 0,  0, 1, 0, 1,  A0};
      tbl[1] = '{0, 1, 0, 1, 0,  0, 1, 1, 0,  A1};
      tbl[2] = '{0, 1, 0, 1, 0,  0, 1, 0, 1,  A0};
      tbl[3] = '{1, 0, 1, 0, 0,  1, 0, 1, 0,  A1};
      tbl[4] = '{1, 0, 0, 1, 0,  1, 0, 0, 1,  A0};
      tbl[5] = '{1, 1, 0, 0, 0,  1, 0, 0, 1,  A0};
      tbl[6] = '{0, 0, 0, 0, 0,  0, 0, 1, 1,  '0};
      tbl[7] = '{0, 1, 0, 1, 1,  0, 1, 1, 1,  A1};
      tbl[8] = '{0, 1, 0, 1, 0,  0, 1, 1, 0,  A1};
      tbl[9] = '{0, 1, 0, 1, 0,  0, 1, 0, 1,  A0};
      rsp_en = 1; force_rdv = 0; chk_pend = 0; rst = 1;
      idle_all();
      @(posedge clk); #1;

      do_reset(1);
      for (int i = 0; i < 10; i++) begin
         m0_if.read = tbl[i].m0r; m0_if.write = tbl[i].m0w; m0_if.address = A0;
         m1_if.read = tbl[i].m1r; m1_if.write = tbl[i].m1w; m1_if.address = A1;
         m0_if.writedata = 16'h1111; m1_if.writedata = 16'h2222;
         s_if.waitrequest = tbl[i].sw;
         settle();
         chk("vec_s_read", s_if.read, tbl[i].er);
         chk("vec_s_write", s_if.write, tbl[i].ew);
         chk("vec_m0_wait", m0_if.waitrequest, tbl[i].e0w);
         chk("vec_m1_wait", m1_if.waitrequest, tbl[i].e1w);
         chk("vec_s_addr", s_if.address, tbl[i].ea);
         advance();
      end
      drain();

      // single m0 write, zero added latency
      do_reset(0);
      m0_if.write = 1; m0_if.address = 22'h000100; m0_if.writedata = 16'hBEEF;
      m0_if.byteenable = 2'b11;
      settle();
      chk("wr_s_write", s_if.write, 1);
      chk("wr_s_read", s_if.read, 0);
      chk("wr_s_addr", s_if.address, 22'h000100);
      chk("wr_s_wdata", s_if.writedata, 16'hBEEF);
      chk("wr_s_be", s_if.byteenable, 2'b11);
      chk("wr_m0_wait", m0_if.waitrequest, 0);
      advance();
      chk("wr_rr_ptr", dut.rr_ptr_q, 1);

      // both masters read after reset: m0 first, then m1
      do_reset(0);
      m0_if.read = 1; m0_if.address = A0;
      m1_if.read = 1; m1_if.address = A1;
      settle();
      chk("rr_m0_first", m0_if.waitrequest, 0);
      chk("rr_m1_held", m1_if.waitrequest, 1);
      chk("rr_addr0", s_if.address, A0);
      advance();
      m0_if.read = 0;
      settle();
      chk("rr_m1_second", m1_if.waitrequest, 0);
      chk("rr_addr1", s_if.address, A1);
      advance();
      drain();

      // lock on m1 write for 4 stalled cycles while m0 waits
      do_reset(0);
      m0_if.write = 1; m0_if.address = 22'h000055; m0_if.writedata = 16'h5555;
      tick();
      m1_if.write = 1; m1_if.address = 22'h3ABCDE; m1_if.writedata = 16'h1234;
      m1_if.byteenable = 2'b01;
      for (int k = 0; k < 5; k++) begin
         s_if.waitrequest = (k < 4);
         settle();
         chk("lk_addr", s_if.address, 22'h3ABCDE);
         chk("lk_wdata", s_if.writedata, 16'h1234);
         chk("lk_be", s_if.byteenable, 2'b01);
         chk("lk_m0_wait", m0_if.waitrequest, 1);
         chk("lk_m1_wait", m1_if.waitrequest, (k < 4) ? 1 : 0);
         advance();
      end
      m1_if.write = 0;
      s_if.waitrequest = 0;
      settle();
      chk("lk_m0_next", m0_if.waitrequest, 0);
      chk("lk_m0_addr", s_if.address, 22'h000055);
      advance();

      // fill the tag FIFO from m1; writes still pass, a pop unblocks the 9th read
      do_reset(0);
      rsp_en = 0;
      for (int i = 0; i < MP; i++) begin
         m1_if.read = 1; m1_if.address = 22'h000100 + AW'(i);
         settle();
         chk("full_fill", m1_if.waitrequest, 0);
         advance();
      end
      m1_if.address = 22'h000108;
      m0_if.write = 1; m0_if.address = 22'h000200;
      settle();
      chk("full_rd_stall", m1_if.waitrequest, 1);
      chk("full_wr_pass", m0_if.waitrequest, 0);
      chk("full_s_write", s_if.write, 1);
      advance();
      m0_if.write = 0;
      settle();
      chk("full_rd_stall2", m1_if.waitrequest, 1);
      chk("full_s_read0", s_if.read, 0);
      advance();
      rsp_en = 1;
      settle();
      chk("full_unblock_rdv", m1_if.readdatavalid, 1);
      chk("full_unblock", m1_if.waitrequest, 0);
      chk("full_s_read1", s_if.read, 1);
      advance();
      drain();

      // interleaved reads with pops coincident with new accepts
      do_reset(0);
      rsp_en = 1;
      chk_pend = 1;
      a0 = 22'h000040; a1 = 22'h000080;
      for (int i = 0; i < 8; i++) begin
         m0_if.read = 1; m0_if.address = a0;
         m1_if.read = 1; m1_if.address = a1;
         settle();
         acc0 = !m0_if.waitrequest;
         acc1 = !m1_if.waitrequest;
         chk("il_one_grant", {acc1, acc0}, (i % 2 == 0) ? 2'b01 : 2'b10);
         advance();
         if (acc0) a0 = a0 + 1'b1;
         if (acc1) a1 = a1 + 1'b1;
      end
      chk("il_pend_const", dut.u_fifo.count_o, 3);
      drain();
      chk_pend = 0;

      // reset while LOCKED with 3 reads outstanding
      do_reset(0);
      rsp_en = 0;
      for (int i = 0; i < 3; i++) begin
         m0_if.read = 1; m0_if.address = 22'h000300 + AW'(i);
         tick();
      end
      m0_if.read = 0;
      m1_if.write = 1; m1_if.address = 22'h000400;
      s_if.waitrequest = 1;
      settle();
      chk("mr_lock_wait", m1_if.waitrequest, 1);
      advance();
      chk("mr_locked", dut.state_q, LOCKED);
      chk("mr_pend3", dut.u_fifo.count_o, 3);
      rst = 1;
      force_rdv = 1;
      settle();
      chk("mr_s_read", s_if.read, 0);
      chk("mr_s_write", s_if.write, 0);
      chk("mr_m0_wait", m0_if.waitrequest, 1);
      chk("mr_m1_wait", m1_if.waitrequest, 1);
      chk("mr_no_rdv", {m1_if.readdatavalid, m0_if.readdatavalid}, 0);
      advance();
      chk("mr_pend0", dut.u_fifo.count_o, 0);
      chk("mr_unlocked", dut.state_q, UNLOCKED);
      rst = 0;
      force_rdv = 0;
      idle_all();
      exp_q.delete();
      rsp_q.delete();
      pend_tb = 0;
      rsp_en = 1;
      for (int i = 0; i < 4; i++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
